// File: rtl/fme7_dac_scheduler.sv
// FME-7 (Sunsoft 5B) expansion-audio DAC scheduler: shares one synchronous volume ROM
// across the square channels and sums the lookups with saturation into a 16-bit sample.
module fme7_dac_scheduler #(
  parameter int NUM_CH  = 3,
  parameter int ROM_LAT = 1,
  parameter int ACC_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  ce,
  input  logic [4*NUM_CH-1:0]   ch_level,
  output logic                  rom_rd,
  output logic [5:0]            rom_addr,
  input  logic [ACC_W-1:0]      rom_data,
  output logic [ACC_W-1:0]      sample,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [1:0] LAST_IDX = 2'(NUM_CH - 1);

  state_t                     state_q, state_d;
  logic [1:0]                 idx_q, idx_d;
  logic [NUM_CH-1:0][3:0]     shadow_q, shadow_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic                       pend_q, pend_d;
  logic                       ovr_q, ovr_d;
  logic                       rd_q, rd_d;
  logic [5:0]                 addr_q, addr_d;
  logic [ACC_W-1:0]           sample_q, sample_d;
  logic                       valid_q, valid_d;
  logic                       busy_q, busy_d;

  logic                       start, chDone, ovrSet;
  logic [3:0]                 issueLvl;
  logic [ACC_W:0]             sum;
  logic [ACC_W-1:0]           accSat;

  assign sum    = {1'b0, acc_q} + {1'b0, rom_data};
  assign accSat = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];

  // The level of the channel being issued lives in rom_addr[3:0], so later shadow
  // reloads cannot disturb a lookup that is already in flight.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    pend_d   = pend_q;
    ovr_d    = ovr_q;
    rd_d     = 1'b0;
    addr_d   = addr_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    start    = 1'b0;
    chDone   = 1'b0;
    ovrSet   = 1'b0;
    issueLvl = 4'd0;

    if (ce) shadow_d = ch_level;
    if ((state_q == ISSUE || state_q == WAIT) && ce) begin
      pend_d = 1'b1;
      ovrSet = pend_q;
    end

    unique case (state_q)
      IDLE: start = ce;
      ISSUE: begin
        if (addr_q[3:0] != 4'd0) begin
          cnt_d   = 3'(ROM_LAT);
          state_d = WAIT;
        end else begin
          chDone = 1'b1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          acc_d  = accSat;
          chDone = 1'b1;
        end
      end
      DONE: begin
        if (pend_q || ce) begin
          pend_d = 1'b0;
          start  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (chDone) begin
      if (idx_q == LAST_IDX) begin
        state_d  = DONE;
        sample_d = acc_d;
        valid_d  = 1'b1;
      end else begin
        idx_d   = idx_q + 2'd1;
        state_d = ISSUE;
      end
    end

    if (start) begin
      acc_d   = '0;
      idx_d   = 2'd0;
      state_d = ISSUE;
    end

    if (state_d == ISSUE && (start || chDone)) begin
      issueLvl = shadow_d[idx_d];
      addr_d   = {idx_d, issueLvl};
      rd_d     = (issueLvl != 4'd0);
    end

    if (ovrSet) ovr_d = 1'b1;
    else if (overrun_clr) ovr_d = 1'b0;

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      shadow_q <= '0;
      cnt_q    <= 3'd0;
      acc_q    <= '0;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= 6'd0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else if (!enable) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      shadow_q <= '0;
      cnt_q    <= 3'd0;
      acc_q    <= '0;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= 6'd0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign rom_rd       = rd_q;
  assign rom_addr     = addr_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_fme7_dac_scheduler.sv
// Bench for fme7_dac_scheduler: ROM_LAT=1 and ROM_LAT=3 instances share stimulus and are
// checked every cycle against a slot-timeline model of the conversion schedule.
module tb_fme7_dac_scheduler;
  localparam int NUMCH = 3;

  logic                  clk = 1'b0;
  logic                  resetN, enable, ce, overrunClr;
  logic [11:0]           chLevel;
  logic [1:0]            romRd, sampleValid, busy, overrun;
  logic [1:0][5:0]       romAddr;
  logic [1:0][15:0]      romData, sample;

  int cyc, vectors, miscompares, romMode;
  int mAct[2], mIdx[2], mStart[2], mLvl[2], mAcc[2], mDone[2], mPend[2], mOvr[2], mSample[2];
  int mShadow[2][NUMCH];
  logic rdHist[2][8];
  int addrHist[2][8];

  always #5 clk = ~clk;

  fme7_dac_scheduler #(.NUM_CH(NUMCH), .ROM_LAT(1), .ACC_W(16)) uDutL1 (
    .clk(clk), .reset_n(resetN), .enable(enable), .ce(ce), .ch_level(chLevel),
    .rom_rd(romRd[0]), .rom_addr(romAddr[0]), .rom_data(romData[0]),
    .sample(sample[0]), .sample_valid(sampleValid[0]), .busy(busy[0]),
    .overrun(overrun[0]), .overrun_clr(overrunClr));

  fme7_dac_scheduler #(.NUM_CH(NUMCH), .ROM_LAT(3), .ACC_W(16)) uDutL3 (
    .clk(clk), .reset_n(resetN), .enable(enable), .ce(ce), .ch_level(chLevel),
    .rom_rd(romRd[1]), .rom_addr(romAddr[1]), .rom_data(romData[1]),
    .sample(sample[1]), .sample_valid(sampleValid[1]), .busy(busy[1]),
    .overrun(overrun[1]), .overrun_clr(overrunClr));

  function automatic int latOf(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int romFn(input int addr);
    case (romMode)
      0:       return addr * 256;
      1:       return 65535;
      default: return (addr * 2671) & 65535;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic modelReset(input int k);
    mAct[k] = 0; mIdx[k] = 0; mStart[k] = -10; mLvl[k] = 0; mAcc[k] = 0;
    mDone[k] = -1; mPend[k] = 0; mOvr[k] = 0; mSample[k] = 0;
    for (int i = 0; i < NUMCH; i++) mShadow[k][i] = 0;
  endtask

  // Each channel occupies a slot of 1 cycle (silent) or 1+ROM_LAT cycles, with the
  // ROM result folded into the sum in the slot's final cycle.
  task automatic modelEdge(input bit ceV, input logic [11:0] lvlV, input bit clrV, input bit enV);
    for (int k = 0; k < 2; k++) begin
      bit wasAct, wasDone, adv, st, setOv;
      int slotLen;
      if (!enV) begin
        modelReset(k);
        continue;
      end
      wasAct  = (mAct[k] != 0);
      wasDone = (cyc == mDone[k]);
      adv = 0; st = 0; setOv = 0;
      slotLen = (mLvl[k] != 0) ? 1 + latOf(k) : 1;
      if (wasAct && cyc == mStart[k] + slotLen - 1) begin
        if (mLvl[k] != 0) begin
          mAcc[k] = mAcc[k] + romFn(mIdx[k] * 16 + mLvl[k]);
          if (mAcc[k] > 65535) mAcc[k] = 65535;
        end
        if (mIdx[k] == NUMCH - 1) begin
          mAct[k] = 0;
          mDone[k] = cyc + 1;
          mSample[k] = mAcc[k];
        end else begin
          adv = 1;
        end
      end
      if (ceV) for (int i = 0; i < NUMCH; i++) mShadow[k][i] = int'(lvlV[4*i +: 4]);
      if (wasAct && ceV) begin
        if (mPend[k] != 0) setOv = 1;
        mPend[k] = 1;
      end
      if (!wasAct && !wasDone && ceV) st = 1;
      if (wasDone && (ceV || mPend[k] != 0)) begin
        st = 1;
        mPend[k] = 0;
      end
      if (adv) begin
        mIdx[k]++;
        mStart[k] = cyc + 1;
        mLvl[k] = mShadow[k][mIdx[k]];
      end
      if (st) begin
        mAct[k] = 1; mIdx[k] = 0; mStart[k] = cyc + 1;
        mLvl[k] = mShadow[k][0]; mAcc[k] = 0;
      end
      if (setOv) mOvr[k] = 1;
      else if (clrV) mOvr[k] = 0;
    end
  endtask

  task automatic checkCycle();
    for (int k = 0; k < 2; k++) begin
      bit issueNow;
      rdHist[k][cyc % 8]   = romRd[k];
      addrHist[k][cyc % 8] = int'(romAddr[k]);
      issueNow = (mAct[k] != 0) && (cyc == mStart[k]);
      checkOutput($sformatf("rom_rd L%0d", latOf(k)), romRd[k], issueNow && mLvl[k] != 0);
      checkOutput($sformatf("sample_valid L%0d", latOf(k)), sampleValid[k], cyc == mDone[k]);
      checkOutput($sformatf("busy L%0d", latOf(k)), busy[k], (mAct[k] != 0) || cyc == mDone[k]);
      checkOutput($sformatf("overrun L%0d", latOf(k)), overrun[k], mOvr[k]);
      checkOutput($sformatf("sample L%0d", latOf(k)), sample[k], mSample[k]);
      if (issueNow) checkOutput($sformatf("rom_addr L%0d", latOf(k)), romAddr[k], mIdx[k] * 16 + mLvl[k]);
    end
  endtask

  task automatic applyStimulus(input bit ceV, input logic [11:0] lvlV, input bit clrV, input bit enV);
    ce = ceV; chLevel = lvlV; overrunClr = clrV; enable = enV;
    for (int k = 0; k < 2; k++) begin
      int h;
      h = cyc - latOf(k);
      if (h >= 0 && rdHist[k][h % 8]) romData[k] = 16'(romFn(addrHist[k][h % 8]));
      else romData[k] = 16'($urandom);
    end
    modelEdge(ceV, lvlV, clrV, enV);
    @(posedge clk);
    #1;
    cyc++;
    checkCycle();
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, chLevel, 1'b0, 1'b1);
  endtask

  task automatic asyncReset();
    #2 resetN = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput("async busy", busy[k], 0);
      checkOutput("async rom_rd", romRd[k], 0);
      checkOutput("async rom_addr", romAddr[k], 0);
      checkOutput("async sample", sample[k], 0);
      checkOutput("async valid", sampleValid[k], 0);
      checkOutput("async overrun", overrun[k], 0);
      modelReset(k);
    end
    @(posedge clk);
    #1;
    resetN = 1'b1;
    cyc++;
    checkCycle();
  endtask

  initial begin
    resetN = 1'b0; enable = 1'b0; ce = 1'b0; overrunClr = 1'b0; chLevel = '0;
    romData = '0; romMode = 0; vectors = 0; miscompares = 0; cyc = 0;
    for (int k = 0; k < 2; k++) begin
      modelReset(k);
      for (int i = 0; i < 8; i++) begin rdHist[k][i] = 1'b0; addrHist[k][i] = 0; end
    end
    repeat (3) @(posedge clk);
    #1;
    checkCycle();
    checkOutput("reset rom_addr", romAddr[0], 0);
    resetN = 1'b1;
    applyStimulus(1'b0, 12'h000, 1'b0, 1'b0);
    idleCycles(3);

    $display("[TB] all channels active");
    applyStimulus(1'b1, 12'h321, 1'b0, 1'b1);
    for (int t = 1; t <= 14; t++) begin
      checkOutput("T1 rd L1", romRd[0], t == 1 || t == 3 || t == 5);
      checkOutput("T1 rd L3", romRd[1], t == 1 || t == 5 || t == 9);
      checkOutput("T1 valid L1", sampleValid[0], t == 7);
      checkOutput("T1 valid L3", sampleValid[1], t == 13);
      if (t == 1) checkOutput("T1 addr0", romAddr[0], 6'h01);
      if (t == 3) checkOutput("T1 addr1", romAddr[0], 6'h12);
      if (t == 5) checkOutput("T1 addr2", romAddr[0], 6'h23);
      if (t == 7) checkOutput("T1 sample L1", sample[0], 16'h3600);
      if (t == 13) checkOutput("T1 sample L3", sample[1], 16'h3600);
      applyStimulus(1'b0, 12'h321, 1'b0, 1'b1);
    end

    $display("[TB] silent channels");
    idleCycles(10);
    applyStimulus(1'b1, 12'h050, 1'b0, 1'b1);
    for (int t = 1; t <= 10; t++) begin
      checkOutput("T2 rd L1", romRd[0], t == 2);
      checkOutput("T2 rd L3", romRd[1], t == 2);
      checkOutput("T2 valid L1", sampleValid[0], t == 5);
      checkOutput("T2 valid L3", sampleValid[1], t == 7);
      if (t == 2) checkOutput("T2 addr", romAddr[0], 6'h15);
      if (t == 5) checkOutput("T2 sample L1", sample[0], 16'h1500);
      applyStimulus(1'b0, 12'h050, 1'b0, 1'b1);
    end
    applyStimulus(1'b1, 12'h000, 1'b0, 1'b1);
    for (int t = 1; t <= 6; t++) begin
      checkOutput("T2z rd", romRd, 2'b00);
      checkOutput("T2z valid", sampleValid, (t == 4) ? 2'b11 : 2'b00);
      if (t == 4) checkOutput("T2z sample", sample[0], 16'h0000);
      applyStimulus(1'b0, 12'h000, 1'b0, 1'b1);
    end

    $display("[TB] saturation");
    idleCycles(5);
    romMode = 1;
    applyStimulus(1'b1, 12'hFFF, 1'b0, 1'b1);
    for (int t = 1; t <= 14; t++) begin
      if (t == 7) checkOutput("T3 sat L1", sample[0], 16'hFFFF);
      if (t == 13) checkOutput("T3 sat L3", sample[1], 16'hFFFF);
      applyStimulus(1'b0, 12'hFFF, 1'b0, 1'b1);
    end
    idleCycles(5);
    romMode = 0;

    $display("[TB] pending and overrun");
    applyStimulus(1'b1, 12'h111, 1'b0, 1'b1);
    for (int t = 1; t <= 15; t++) begin
      checkOutput("T4 overrun", overrun[0], t >= 5);
      checkOutput("T4 rd", romRd[0], t == 1 || t == 3 || t == 5 || t == 8 || t == 10 || t == 12);
      checkOutput("T4 valid", sampleValid[0], t == 7 || t == 14);
      if (t == 7) checkOutput("T4 sample first", sample[0], 16'h3500);
      if (t == 14) checkOutput("T4 sample second", sample[0], 16'h3600);
      applyStimulus(t == 2 || t == 4, (t < 2) ? 12'h111 : 12'h222, 1'b0, 1'b1);
    end
    idleCycles(30);
    checkOutput("T4 overrun sticky", overrun, 2'b11);
    applyStimulus(1'b0, 12'h222, 1'b1, 1'b1);
    checkOutput("T4 overrun clr", overrun, 2'b00);
    applyStimulus(1'b1, 12'h111, 1'b0, 1'b1);
    applyStimulus(1'b1, 12'h111, 1'b0, 1'b1);
    applyStimulus(1'b1, 12'h111, 1'b1, 1'b1);
    checkOutput("T4 set beats clr", overrun, 2'b11);
    idleCycles(30);
    applyStimulus(1'b0, 12'h111, 1'b1, 1'b1);

    $display("[TB] enable abort");
    applyStimulus(1'b1, 12'h321, 1'b0, 1'b1);
    applyStimulus(1'b0, 12'h321, 1'b0, 1'b1);
    applyStimulus(1'b0, 12'h321, 1'b0, 1'b1);
    applyStimulus(1'b0, 12'h321, 1'b0, 1'b0);
    checkOutput("T6 busy", busy, 2'b00);
    checkOutput("T6 sample", sample[0], 16'h0000);
    for (int t = 0; t < 12; t++) begin
      applyStimulus(1'b0, 12'h321, 1'b0, 1'b1);
      checkOutput("T6 no valid", sampleValid, 2'b00);
    end

    $display("[TB] asynchronous reset");
    applyStimulus(1'b1, 12'h321, 1'b0, 1'b1);
    idleCycles(20);
    checkOutput("T6 pre-reset sample", sample[0], 16'h3600);
    applyStimulus(1'b1, 12'h321, 1'b0, 1'b1);
    applyStimulus(1'b0, 12'h321, 1'b0, 1'b1);
    asyncReset();
    idleCycles(5);

    $display("[TB] randomized traffic");
    romMode = 2;
    for (int n = 0; n < 2500; n++) begin
      logic [11:0] lv;
      for (int i = 0; i < NUMCH; i++)
        lv[4*i +: 4] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      applyStimulus($urandom_range(0, 9) == 0, lv, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 299) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
